// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INST_W           = 32;
  localparam int          ADDR_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_inst_queue.sv
// ============================================================================
// Module   : ifetch_inst_queue
// Purpose  : Circular instruction queue of {inst, pc} with push/pop/flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch_inst_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  iq_entry_t            push_data,
  input  logic                 pop,
  input  logic                 flush,
  output iq_entry_t            head,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  iq_entry_t              mem_q [DEPTH];
  iq_entry_t              mem_d [DEPTH];
  logic [DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]     count_q, count_d;
  logic                   empty;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is allowed only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + DEPTH_LOG'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
      end
      count_d = count_q + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// Module   : ifetch
// Purpose  : PC, single-outstanding fetch FSM and redirect handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifetch
  import ifetch_pkg::*;
#(
  parameter int          QDEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              ic_req_valid,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_ready,
  input  logic              ic_resp_valid,
  input  logic [INST_W-1:0] ic_resp_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;

  logic                q_push;
  logic                q_pop;
  logic                q_full;
  logic [QDEPTH_LOG:0] q_count;
  iq_entry_t           q_head;
  logic                redirect_fire;
  logic                req_fire;

  assign redirect_fire = redirect_valid & rdy_in;
  // Gated by reset so no request is ever presented while the cache is held in reset.
  assign ic_req_valid  = rst_in & (state_q == ST_IDLE) & rdy_in & ~redirect_valid & ~q_full;
  assign req_fire      = ic_req_valid & ic_req_ready;
  assign ic_req_addr   = pc_q;

  assign inst_valid    = (q_count != '0);
  assign inst_out      = q_head.inst;
  assign inst_pc       = q_head.pc;
  assign q_pop         = inst_valid & inst_ready & rdy_in & ~redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    q_push   = 1'b0;
    if (redirect_fire) begin
      pc_d = redirect_pc;
      // A response landing with the redirect retires the outstanding request.
      case (state_q)
        ST_WAIT, ST_DROP: state_d = ic_resp_valid ? ST_IDLE : ST_DROP;
        default:          state_d = ST_IDLE;
      endcase
    end else begin
      if (req_fire) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = ST_WAIT;
      end
      if (ic_resp_valid) begin
        case (state_q)
          ST_WAIT: begin
            q_push  = 1'b1;
            state_d = ST_IDLE;
          end
          ST_DROP: state_d = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  ifetch_inst_queue #(
    .DEPTH_LOG (QDEPTH_LOG)
  ) u_queue (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (q_push),
    .push_data ('{inst: ic_resp_inst, pc: req_pc_q}),
    .pop       (q_pop),
    .flush     (redirect_fire),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module   : tb_ifetch
// Purpose  : Directed self-checking bench for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_cmp;
  int n_bad;

  ifetch #(
    .QDEPTH_LOG (2),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_inst   (ic_resp_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one request at address a and return word w with 1-cycle latency.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] w);
    check("req_valid", 64'(ic_req_valid), 64'd1);
    check("req_addr", 64'(ic_req_addr), 64'(a));
    cyc();
    ic_resp_valid = 1'b1;
    ic_resp_inst  = w;
    #1;
    check("req_busy", 64'(ic_req_valid), 64'd0);
    cyc();
    ic_resp_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_in = 1'b0; rdy_in = 1'b1; ic_req_ready = 1'b1;
    ic_resp_valid = 1'b0; ic_resp_inst = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    cyc(); cyc();
    check("rst_req_valid", 64'(ic_req_valid), 64'd0);
    check("rst_req_addr", 64'(ic_req_addr), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_out", 64'(inst_out), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);

    rst_in = 1'b1;
    #1;
    fetch_one(32'h0, 32'h1111_1111);
    check("first_valid", 64'(inst_valid), 64'd1);
    check("first_pc", 64'(inst_pc), 64'd0);
    check("first_inst", 64'(inst_out), 64'h1111_1111);
    fetch_one(32'h4, 32'h2222_2222);
    fetch_one(32'h8, 32'h3333_3333);
    fetch_one(32'hC, 32'h4444_4444);
    check("full_count", 64'(dut.u_queue.count_q), 64'd4);
    check("full_no_req", 64'(ic_req_valid), 64'd0);
    cyc();
    check("full_still_no_req", 64'(ic_req_valid), 64'd0);

    inst_ready = 1'b1;
    #1;
    check("pop_head_pc", 64'(inst_pc), 64'd0);
    cyc();
    inst_ready = 1'b0;
    #1;
    check("after_pop_req", 64'(ic_req_valid), 64'd1);
    check("after_pop_addr", 64'(ic_req_addr), 64'h10);
    check("after_pop_head", 64'(inst_pc), 64'h4);

    // Pop together with request to 0x10, then push and pop in the same cycle.
    inst_ready = 1'b1;
    cyc();
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h5555_5555;
    #1;
    check("pp_count_before", 64'(dut.u_queue.count_q), 64'd2);
    cyc();
    ic_resp_valid = 1'b0; inst_ready = 1'b0;
    #1;
    check("pp_count_after", 64'(dut.u_queue.count_q), 64'd2);
    check("pp_head_pc", 64'(inst_pc), 64'hC);
    check("pp_head_inst", 64'(inst_out), 64'h4444_4444);
    check("pp_req_addr", 64'(ic_req_addr), 64'h14);

    // Request to 0x14 accepted, then redirect while WAIT.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("rd_no_req", 64'(ic_req_valid), 64'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("rd_flushed", 64'(inst_valid), 64'd0);
    check("rd_state_drop", 64'(dut.state_q), 64'(ST_DROP));
    check("rd_drop_no_req", 64'(ic_req_valid), 64'd0);
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hDEAD_BEEF;
    cyc();
    ic_resp_valid = 1'b0;
    #1;
    check("drop_not_enq", 64'(inst_valid), 64'd0);
    check("rd_req_valid", 64'(ic_req_valid), 64'd1);
    check("rd_req_addr", 64'(ic_req_addr), 64'h100);

    // Request to 0x100 accepted; redirect and response in the same cycle.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    ic_resp_valid = 1'b1; ic_resp_inst = 32'hCAFE_F00D;
    cyc();
    redirect_valid = 1'b0; ic_resp_valid = 1'b0;
    #1;
    check("rr_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    check("rr_req_valid", 64'(ic_req_valid), 64'd1);
    check("rr_req_addr", 64'(ic_req_addr), 64'h200);
    check("rr_inst_valid", 64'(inst_valid), 64'd0);

    // Redirect while IDLE to the top word to exercise PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    #1;
    fetch_one(32'hFFFF_FFFC, 32'h6666_6666);
    check("wrap_addr", 64'(ic_req_addr), 64'h0);
    check("wrap_head_pc", 64'(inst_pc), 64'hFFFF_FFFC);
    check("wrap_head_inst", 64'(inst_out), 64'h6666_6666);

    // Request to 0x0 accepted, then rdy_in low for 3 cycles.
    cyc();
    rdy_in = 1'b0; inst_ready = 1'b1;
    ic_resp_valid = 1'b1; ic_resp_inst = 32'h7777_7777;
    #1;
    check("frz1_no_req", 64'(ic_req_valid), 64'd0);
    cyc();
    ic_resp_valid = 1'b0;
    #1;
    check("frz2_no_req", 64'(ic_req_valid), 64'd0);
    check("frz2_count", 64'(dut.u_queue.count_q), 64'd2);
    check("frz2_head", 64'(inst_pc), 64'hFFFF_FFFC);
    cyc();
    check("frz3_no_req", 64'(ic_req_valid), 64'd0);
    check("frz3_count", 64'(dut.u_queue.count_q), 64'd2);
    check("frz3_addr", 64'(ic_req_addr), 64'h4);
    rdy_in = 1'b1;
    #1;
    check("thaw_req", 64'(ic_req_valid), 64'd1);
    check("thaw_addr", 64'(ic_req_addr), 64'h4);
    cyc();
    inst_ready = 1'b0;
    #1;
    check("thaw_head", 64'(inst_pc), 64'h0);
    check("thaw_inst", 64'(inst_out), 64'h7777_7777);

    // Reset with a request outstanding.
    rst_in = 1'b0;
    #1;
    check("mid_rst_req", 64'(ic_req_valid), 64'd0);
    check("mid_rst_addr", 64'(ic_req_addr), 64'd0);
    check("mid_rst_valid", 64'(inst_valid), 64'd0);
    check("mid_rst_state", 64'(dut.state_q), 64'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
